// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: register map,
// address legality check, host handshake states and grant sources.
package regfile_wb_arbiter_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] REG_PI0     = 6'd28;
    localparam logic [ADDR_W-1:0] REG_PI1     = 6'd29;
    localparam logic [ADDR_W-1:0] REG_LAST_GP = 6'd29;
    localparam logic [ADDR_W-1:0] REG_AUX0    = 6'd32;
    localparam logic [ADDR_W-1:0] REG_AUX1    = 6'd33;
    localparam logic [ADDR_W-1:0] REG_WR      = 6'd34;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_WAIT = 2'd1,
        H_ACK  = 2'd2
    } host_state_e;

    typedef enum logic [2:0] {
        SRC_NONE  = 3'd0,
        SRC_ALU   = 3'd1,
        SRC_PEND0 = 3'd2,
        SRC_PEND1 = 3'd3,
        SRC_HOST  = 3'd4
    } grant_src_e;

    // r30, r31 and everything above r34 have no backing storage.
    function automatic logic addr_is_valid(input logic [ADDR_W-1:0] addr);
        return (addr <= REG_LAST_GP) || (addr == REG_AUX0) ||
               (addr == REG_AUX1) || (addr == REG_WR);
    endfunction

endpackage

// File: rtl/wb_port_sampler.sv
// Input-port change detector: keeps a shadow copy of the pins and raises a
// pending flag whenever they move; the latest value always wins.
module wb_port_sampler
    import regfile_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pins,
    input  logic              grant,
    output logic              pend,
    output logic [DATA_W-1:0] value
);

    logic [DATA_W-1:0] shadow_r;
    logic              pend_r;

    // Shadow/pending update; a change coinciding with a grant re-arms the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= {DATA_W{1'b0}};
            pend_r   <= 1'b0;
        end else if (pins != shadow_r) begin
            shadow_r <= pins;
            pend_r   <= 1'b1;
        end else if (grant) begin
            pend_r   <= 1'b0;
        end else begin
            pend_r   <= pend_r;
        end
    end

    assign pend  = pend_r;
    assign value = shadow_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single-port register-file writeback arbiter for ALU, input-port sampler and
// host loads. Port sampling is built only when WB_PORT_SAMPLE_EN is defined.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Alu_Wr_Req,
    input  logic [ADDR_W-1:0] Alu_Wr_Addr,
    input  logic [DATA_W-1:0] Alu_Wr_Data,
    output logic              Alu_Stall,
    input  logic              Host_Valid,
    input  logic [ADDR_W-1:0] Host_Addr,
    input  logic [DATA_W-1:0] Host_Data,
    output logic              Host_Ready,
    input  logic [DATA_W-1:0] Pi0,
    input  logic [DATA_W-1:0] Pi1,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [DATA_W-1:0] Wr_Data,
    output logic              Addr_Err
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    host_state_e       host_state_r;
    host_state_e       host_state_nxt_s;
    logic [CNT_W-1:0]  wait_cnt_r;

    logic              pend0_s;
    logic              pend1_s;
    logic [DATA_W-1:0] pin0_val_s;
    logic [DATA_W-1:0] pin1_val_s;

    logic              host_req_s;
    logic              host_starved_s;
    logic              host_grant_s;
    logic              grant_pend0_s;
    logic              grant_pend1_s;
    grant_src_e        grant_src_s;
    logic [ADDR_W-1:0] grant_addr_s;
    logic [DATA_W-1:0] grant_data_s;

    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              addr_err_r;
    logic              host_ready_r;

`ifdef WB_PORT_SAMPLE_EN
    wb_port_sampler u_port0 (
        .clk   (Clock),
        .rst_n (Reset_n),
        .pins  (Pi0),
        .grant (grant_pend0_s),
        .pend  (pend0_s),
        .value (pin0_val_s)
    );

    wb_port_sampler u_port1 (
        .clk   (Clock),
        .rst_n (Reset_n),
        .pins  (Pi1),
        .grant (grant_pend1_s),
        .pend  (pend1_s),
        .value (pin1_val_s)
    );
`else
    logic unused_pins_s;
    assign unused_pins_s = ^{Pi0, Pi1, grant_pend0_s, grant_pend1_s};
    assign pend0_s       = 1'b0;
    assign pend1_s       = 1'b0;
    assign pin0_val_s    = {DATA_W{1'b0}};
    assign pin1_val_s    = {DATA_W{1'b0}};
`endif

    // Fixed-priority arbitration; a starved host outranks everything.
    always_comb begin
        host_req_s     = (host_state_r == H_WAIT) && Host_Valid;
        host_starved_s = host_req_s && (wait_cnt_r == LIMIT_C);
        grant_src_s    = SRC_NONE;
        grant_addr_s   = {ADDR_W{1'b0}};
        grant_data_s   = {DATA_W{1'b0}};
        if (host_starved_s) begin
            grant_src_s  = SRC_HOST;
            grant_addr_s = Host_Addr;
            grant_data_s = Host_Data;
        end else if (Alu_Wr_Req) begin
            grant_src_s  = SRC_ALU;
            grant_addr_s = Alu_Wr_Addr;
            grant_data_s = Alu_Wr_Data;
        end else if (pend0_s) begin
            grant_src_s  = SRC_PEND0;
            grant_addr_s = REG_PI0;
            grant_data_s = pin0_val_s;
        end else if (pend1_s) begin
            grant_src_s  = SRC_PEND1;
            grant_addr_s = REG_PI1;
            grant_data_s = pin1_val_s;
        end else if (host_req_s) begin
            grant_src_s  = SRC_HOST;
            grant_addr_s = Host_Addr;
            grant_data_s = Host_Data;
        end else begin
            grant_src_s  = SRC_NONE;
        end
    end

    assign host_grant_s  = (grant_src_s == SRC_HOST);
    assign grant_pend0_s = (grant_src_s == SRC_PEND0);
    assign grant_pend1_s = (grant_src_s == SRC_PEND1);
    assign Alu_Stall     = Alu_Wr_Req && host_starved_s;

    // Host handshake next state; H_ACK always returns to idle so a held
    // Host_Valid cannot be taken twice.
    always_comb begin
        host_state_nxt_s = host_state_r;
        case (host_state_r)
            H_IDLE: begin
                if (Host_Valid) host_state_nxt_s = H_WAIT;
                else            host_state_nxt_s = H_IDLE;
            end
            H_WAIT: begin
                if (host_grant_s) host_state_nxt_s = H_ACK;
                else              host_state_nxt_s = H_WAIT;
            end
            H_ACK:   host_state_nxt_s = H_IDLE;
            default: host_state_nxt_s = H_IDLE;
        endcase
    end

    // Host handshake state register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            host_state_r <= H_IDLE;
        end else begin
            host_state_r <= host_state_nxt_s;
        end
    end

    // Host wait counter, saturating at the starvation threshold.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (host_grant_s) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (Host_Valid && (host_state_r != H_ACK) && (wait_cnt_r != LIMIT_C)) begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Registered write port; illegal addresses are consumed but only flagged.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {ADDR_W{1'b0}};
            wr_data_r    <= {DATA_W{1'b0}};
            addr_err_r   <= 1'b0;
            host_ready_r <= 1'b0;
        end else begin
            host_ready_r <= host_grant_s;
            if (grant_src_s != SRC_NONE) begin
                if (addr_is_valid(grant_addr_s)) begin
                    wr_en_r    <= 1'b1;
                    wr_addr_r  <= grant_addr_s;
                    wr_data_r  <= grant_data_s;
                    addr_err_r <= 1'b0;
                end else begin
                    wr_en_r    <= 1'b0;
                    addr_err_r <= 1'b1;
                end
            end else begin
                wr_en_r    <= 1'b0;
                addr_err_r <= 1'b0;
            end
        end
    end

    assign Wr_En      = wr_en_r;
    assign Wr_Addr    = wr_addr_r;
    assign Wr_Data    = wr_data_r;
    assign Addr_Err   = addr_err_r;
    assign Host_Ready = host_ready_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural model of the arbiter.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;
`ifdef WB_PORT_SAMPLE_EN
    localparam bit PS_EN = 1'b1;
`else
    localparam bit PS_EN = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Alu_Wr_Req;
    logic [5:0]  Alu_Wr_Addr;
    logic [15:0] Alu_Wr_Data;
    logic        Alu_Stall;
    logic        Host_Valid;
    logic [5:0]  Host_Addr;
    logic [15:0] Host_Data;
    logic        Host_Ready;
    logic [15:0] Pi0;
    logic [15:0] Pi1;
    logic        Wr_En;
    logic [5:0]  Wr_Addr;
    logic [15:0] Wr_Data;
    logic        Addr_Err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: host phase 0=not seen, 1=waiting, 2=acknowledging
    int          m_hs;
    int          m_wait;
    bit          m_p0, m_p1;
    logic [15:0] m_sh0, m_sh1;
    bit          m_stall_last;
    bit          exp_en, exp_err, exp_ready;
    logic [5:0]  exp_addr;
    logic [15:0] exp_data;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Alu_Wr_Req  (Alu_Wr_Req),
        .Alu_Wr_Addr (Alu_Wr_Addr),
        .Alu_Wr_Data (Alu_Wr_Data),
        .Alu_Stall   (Alu_Stall),
        .Host_Valid  (Host_Valid),
        .Host_Addr   (Host_Addr),
        .Host_Data   (Host_Data),
        .Host_Ready  (Host_Ready),
        .Pi0         (Pi0),
        .Pi1         (Pi1),
        .Wr_En       (Wr_En),
        .Wr_Addr     (Wr_Addr),
        .Wr_Data     (Wr_Data),
        .Addr_Err    (Addr_Err)
    );

    always #5 Clock = ~Clock;

    function automatic bit addr_ok(input logic [5:0] a);
        return (a <= 6'd29) || (a == 6'd32) || (a == 6'd33) || (a == 6'd34);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_hs = 0; m_wait = 0; m_p0 = 1'b0; m_p1 = 1'b0;
        m_sh0 = 16'd0; m_sh1 = 16'd0; m_stall_last = 1'b0;
        exp_en = 1'b0; exp_err = 1'b0; exp_ready = 1'b0;
        exp_addr = 6'd0; exp_data = 16'd0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".wr_en"},      16'(Wr_En),      16'(exp_en));
        chk({tag, ".wr_addr"},    16'(Wr_Addr),    16'(exp_addr));
        chk({tag, ".wr_data"},    Wr_Data,         exp_data);
        chk({tag, ".addr_err"},   16'(Addr_Err),   16'(exp_err));
        chk({tag, ".host_ready"}, 16'(Host_Ready), 16'(exp_ready));
    endtask

    // One clock cycle; called at posedge+1 with inputs already driven.
    task automatic step();
        int          src;
        logic [5:0]  ga;
        logic [15:0] gd;
        bit          hreq, starved, exp_stall;
        #2;
        hreq    = (m_hs == 1) && (Host_Valid == 1'b1);
        starved = hreq && (m_wait == LIMIT);
        if (starved)                  src = 4;
        else if (Alu_Wr_Req == 1'b1)  src = 1;
        else if (m_p0)                src = 2;
        else if (m_p1)                src = 3;
        else if (hreq)                src = 4;
        else                          src = 0;
        exp_stall    = (Alu_Wr_Req == 1'b1) && starved;
        m_stall_last = exp_stall;
        chk("alu_stall", 16'(Alu_Stall), 16'(exp_stall));
        @(posedge Clock);
        ga = 6'd0; gd = 16'd0;
        case (src)
            1: begin ga = Alu_Wr_Addr; gd = Alu_Wr_Data; end
            2: begin ga = 6'd28; gd = m_sh0; end
            3: begin ga = 6'd29; gd = m_sh1; end
            4: begin ga = Host_Addr; gd = Host_Data; end
            default: ;
        endcase
        exp_ready = (src == 4);
        exp_en    = 1'b0;
        exp_err   = 1'b0;
        if (src != 0) begin
            if (addr_ok(ga)) begin
                exp_en = 1'b1; exp_addr = ga; exp_data = gd;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (src == 4) m_wait = 0;
        else if (Host_Valid == 1'b1 && m_hs != 2 && m_wait < LIMIT) m_wait++;
        if (m_hs == 0)      m_hs = (Host_Valid == 1'b1) ? 1 : 0;
        else if (m_hs == 1) m_hs = (src == 4) ? 2 : 1;
        else                m_hs = 0;
        if (PS_EN) begin
            if (Pi0 != m_sh0) begin m_sh0 = Pi0; m_p0 = 1'b1; end
            else if (src == 2) m_p0 = 1'b0;
            if (Pi1 != m_sh1) begin m_sh1 = Pi1; m_p1 = 1'b1; end
            else if (src == 3) m_p1 = 1'b0;
        end
        #1;
        check_outputs("cycle");
    endtask

    logic [5:0] addr_hist [0:4];
    logic       stall_hist [1:5];

    initial begin
        Reset_n = 1'b0; Alu_Wr_Req = 1'b0; Alu_Wr_Addr = 6'd0; Alu_Wr_Data = 16'd0;
        Host_Valid = 1'b0; Host_Addr = 6'd0; Host_Data = 16'd0;
        Pi0 = 16'd0; Pi1 = 16'd0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_outputs("reset");
        chk("reset.alu_stall", 16'(Alu_Stall), 16'd0);
        Reset_n = 1'b1;

        // ALU write alone
        Alu_Wr_Req = 1'b1; Alu_Wr_Addr = 6'd5; Alu_Wr_Data = 16'h1234;
        step();
        chk("alu.wr_en", 16'(Wr_En), 16'd1);
        chk("alu.wr_addr", 16'(Wr_Addr), 16'd5);
        chk("alu.wr_data", Wr_Data, 16'h1234);
        Alu_Wr_Req = 1'b0;
        step();
        chk("idle.hold_addr", 16'(Wr_Addr), 16'd5);
        chk("idle.wr_en", 16'(Wr_En), 16'd0);

        // Host write to illegal r31
        Host_Valid = 1'b1; Host_Addr = 6'd31; Host_Data = 16'h5555;
        step();
        step();
        chk("bad.addr_err", 16'(Addr_Err), 16'd1);
        chk("bad.wr_en", 16'(Wr_En), 16'd0);
        chk("bad.host_ready", 16'(Host_Ready), 16'd1);
        Host_Valid = 1'b0;
        step();
        chk("bad.err_pulse", 16'(Addr_Err), 16'd0);

        // Host starvation against a continuously busy ALU
        Host_Valid = 1'b1; Host_Addr = 6'd10; Host_Data = 16'hBEEF;
        Alu_Wr_Req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            Alu_Wr_Addr = 6'($urandom_range(0, 29));
            Alu_Wr_Data = 16'($urandom);
            #2;
            stall_hist[c] = Alu_Stall;
            step();
        end
        chk("starve.stall_c4", 16'(stall_hist[4]), 16'd0);
        chk("starve.stall_c5", 16'(stall_hist[5]), 16'd1);
        chk("starve.wr_addr", 16'(Wr_Addr), 16'd10);
        chk("starve.wr_data", Wr_Data, 16'hBEEF);
        chk("starve.ready", 16'(Host_Ready), 16'd1);
        Host_Valid = 1'b0; Alu_Wr_Req = 1'b0;
        step();

`ifdef WB_PORT_SAMPLE_EN
        // Single port change, then stable pins
        Pi0 = 16'h00A5;
        step();
        step();
        chk("pi0.wr_addr", 16'(Wr_Addr), 16'd28);
        chk("pi0.wr_data", Wr_Data, 16'h00A5);
        chk("pi0.wr_en", 16'(Wr_En), 16'd1);
        repeat (3) step();
        chk("pi0.no_repeat", 16'(Wr_En), 16'd0);

        // Both ports change under three ALU writes
        Pi0 = 16'h1111; Pi1 = 16'h2222; Alu_Wr_Req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) Alu_Wr_Req = 1'b0;
            Alu_Wr_Addr = 6'(c + 1);
            step();
            addr_hist[c] = Wr_Addr;
        end
        chk("both.seq0", 16'(addr_hist[0]), 16'd1);
        chk("both.seq2", 16'(addr_hist[2]), 16'd3);
        chk("both.seq3", 16'(addr_hist[3]), 16'd28);
        chk("both.seq4", 16'(addr_hist[4]), 16'd29);
`else
        Pi0 = 16'h00A5;
        repeat (3) step();
        chk("pi0.ignored", 16'(Wr_En), 16'd0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (!m_stall_last) begin
                Alu_Wr_Req  = ($urandom_range(0, 1) == 1);
                Alu_Wr_Addr = 6'($urandom_range(0, 39));
                Alu_Wr_Data = 16'($urandom);
            end
            if (exp_ready) Host_Valid = 1'b0;
            else if (!Host_Valid && $urandom_range(0, 3) == 0) begin
                Host_Valid = 1'b1;
                Host_Addr  = 6'($urandom_range(0, 39));
                Host_Data  = 16'($urandom);
            end
            if ($urandom_range(0, 9) == 0) Pi0 = 16'($urandom);
            if ($urandom_range(0, 9) == 0) Pi1 = 16'($urandom);
            step();
        end

        // Drain outstanding requests
        for (int i = 0; i < 20; i++) begin
            if (!m_stall_last) Alu_Wr_Req = 1'b0;
            if (exp_ready) Host_Valid = 1'b0;
            step();
        end

        // Reset while the host is waiting
        Alu_Wr_Req = 1'b1; Alu_Wr_Addr = 6'd7; Alu_Wr_Data = 16'h7777;
        Host_Valid = 1'b1; Host_Addr = 6'd12; Host_Data = 16'hCAFE;
        step();
        step();
        chk("prerst.wr_addr", 16'(Wr_Addr), 16'd7);
        #3;
        Reset_n = 1'b0;
        #1;
        model_reset();
        Pi0 = 16'd0; Pi1 = 16'd0;
        check_outputs("rst_async");
        chk("rst_async.alu_stall", 16'(Alu_Stall), 16'd0);
        Host_Valid = 1'b0; Alu_Wr_Req = 1'b0;
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        repeat (4) step();
        chk("rst.no_write", 16'(Wr_En), 16'd0);
        Pi0 = 16'h0042; Pi1 = 16'h0099;
        repeat (4) step();
`ifdef WB_PORT_SAMPLE_EN
        chk("rst.pi1_written", 16'(Wr_Addr), 16'd29);
`else
        chk("rst.pi_ignored", 16'(Wr_Addr), 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
